regfile_write_scheduler: RTL and testbench

Arbitrates the single write port of the 32×32 register file between the ALU writeback stream and the load-unit writeback stream. It also keeps a pending-write scoreboard so issue logic can stall on RAW hazards. It sits between the execute/memory stages and the register file, and drives the file's `write_address`/`write_value` directly.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/regfile_write_scheduler.sv | 105 ++++++++++
 tb/tb_regfile_write_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, writeback request bundle and arbiter state encoding
// for the register-file write scheduler.
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Remembers which side won the most recent contended cycle.
    typedef enum logic {
        RR_LAST_A = 1'b0,
        RR_LAST_B = 1'b1
    } rr_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Uncontended requests are granted
// immediately; contended cycles alternate, starting with B after reset.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b,
    output logic last_b
);

    rr_state_t state;

    // The side that did not win the last contended cycle gets priority now.
    assign grant_b = req_b && (!req_a || (state == RR_LAST_A));
    assign grant_a = req_a && (!req_b || (state == RR_LAST_B));
    assign last_b  = (state == RR_LAST_B);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RR_LAST_A;
        end else if (req_a && req_b) begin
            state <= grant_b ? RR_LAST_B : RR_LAST_A;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register file write port between ALU and load writeback,
// and tracks pending destination registers for RAW hazard stalls.
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    output logic [AW-1:0]   write_address,
    output logic [XLEN-1:0] write_value,
    input  logic [AW-1:0]   check_addr_1,
    input  logic [AW-1:0]   check_addr_2,
    output logic            busy_1,
    output logic            busy_2,
    output logic [AW:0]     pending_count,
    output logic            error,
    output logic            last_b
);

    localparam int NR = 1 << AW;
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    // Handshake: a side transfers on valid && ready in the same cycle; ready
    // is combinational from valid and arbiter state, and at most one side is
    // ready per cycle. The register file commits on the same edge.
    wb_req_t req_a, req_b, win;
    logic    grant_a, grant_b, fire;

    logic [NR-1:0] pending, pending_next, set_vec, clr_vec;
    logic          set_hit, clr_hit, same_rd, inc, dec, viol;

    assign req_a = '{valid: a_valid, rd: a_rd, data: a_data};
    assign req_b = '{valid: b_valid, rd: b_rd, data: b_data};

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_a   (req_a.valid),
        .req_b   (req_b.valid),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .last_b  (last_b)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        win           = grant_b ? req_b : req_a;
        fire          = grant_a || grant_b;
        write_address = fire ? win.rd   : '0;
        write_value   = fire ? win.data : '0;

        set_hit = issue_valid && (issue_rd != '0);
        clr_hit = fire && (win.rd != '0);
        same_rd = (issue_rd == win.rd);

        set_vec = '0;
        clr_vec = '0;
        if (set_hit) set_vec[issue_rd] = 1'b1;
        if (clr_hit) clr_vec[win.rd]   = 1'b1;
        // Set applied after clear: a new producer outranks a retiring one.
        pending_next = (pending & ~clr_vec) | set_vec;

        inc = set_hit && !pending[issue_rd];
        dec = clr_hit && pending[win.rd] && !(set_hit && same_rd);

        viol = (clr_hit && !pending[win.rd])
            || (set_hit && pending[issue_rd] && !(clr_hit && same_rd))
            || (a_valid && b_valid && (a_rd == b_rd) && (a_rd != '0));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending       <= '0;
            pending_count <= '0;
            error         <= 1'b0;
        end else begin
            pending <= pending_next;
            if (inc && !dec) begin
                pending_count <= pending_count + ONE;
            end else if (dec && !inc) begin
                pending_count <= pending_count - ONE;
            end
            error <= error || viol;
        end
    end

    // Bit 0 is never set, so x0 always reads not busy.
    assign busy_1 = pending[check_addr_1];
    assign busy_2 = pending[check_addr_2];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed scenarios plus
// randomized traffic against a set-of-pending-registers reference model.
module tb_regfile_write_scheduler;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clock;
    logic            reset_n;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            a_valid;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;
    logic            b_valid;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;
    logic [AW-1:0]   write_address;
    logic [XLEN-1:0] write_value;
    logic [AW-1:0]   check_addr_1;
    logic [AW-1:0]   check_addr_2;
    logic            busy_1;
    logic            busy_2;
    logic [AW:0]     pending_count;
    logic            error;
    logic            last_b;

    int n_vec;
    int n_err;

    // Reference model: which registers await a write, who won last contention,
    // and whether a protocol violation has ever been seen.
    bit m_pend[32];
    bit m_last_b;
    bit m_err;

    regfile_write_scheduler #(.XLEN(XLEN), .AW(AW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .a_valid       (a_valid),
        .a_rd          (a_rd),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_valid       (b_valid),
        .b_rd          (b_rd),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .write_address (write_address),
        .write_value   (write_value),
        .check_addr_1  (check_addr_1),
        .check_addr_2  (check_addr_2),
        .busy_1        (busy_1),
        .busy_2        (busy_2),
        .pending_count (pending_count),
        .error         (error),
        .last_b        (last_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic void m_grant(output bit ga, output bit gb);
        ga = 1'b0;
        gb = 1'b0;
        if (a_valid && b_valid) begin
            if (m_last_b) ga = 1'b1;
            else          gb = 1'b1;
        end else begin
            ga = a_valid;
            gb = b_valid;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_last_b = 1'b0;
        m_err    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit ga, gb, fire;
        int wr, ir;
        m_grant(ga, gb);
        fire = ga || gb;
        wr   = gb ? int'(b_rd) : int'(a_rd);
        ir   = int'(issue_rd);
        if (a_valid && b_valid) m_last_b = gb;
        if (fire && wr != 0 && !m_pend[wr]) m_err = 1'b1;
        if (issue_valid && ir != 0 && m_pend[ir] && !(fire && wr == ir)) m_err = 1'b1;
        if (a_valid && b_valid && a_rd == b_rd && a_rd != 0) m_err = 1'b1;
        if (fire && wr != 0) m_pend[wr] = 1'b0;
        if (issue_valid && ir != 0) m_pend[ir] = 1'b1;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_rd     = '0;
        a_valid      = 1'b0;
        a_rd         = '0;
        a_data       = '0;
        b_valid      = 1'b0;
        b_rd         = '0;
        b_data       = '0;
        check_addr_1 = '0;
        check_addr_2 = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        n_vec += 6;
        if (pending_count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", pending_count); end
        if (error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", error); end
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready); end
        if (write_address !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", write_address); end
        if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b %b want 0 0", busy_1, busy_2); end
        if (last_b !== 1'b0) begin n_err++; $display("FAIL reset_last_b: got %b want 0", last_b); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_a_only();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        idle_inputs();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF; check_addr_1 = 5'd5;
        #1;
        n_vec += 5;
        if (busy_1 !== 1'b1) begin n_err++; $display("FAIL a_only_busy_before: got %b want 1", busy_1); end
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL a_only_ready: got a=%b b=%b want 1 0", a_ready, b_ready); end
        if (write_address !== 5'd5) begin n_err++; $display("FAIL a_only_waddr: got %0d want 5", write_address); end
        if (write_value !== 32'hDEADBEEF) begin n_err++; $display("FAIL a_only_wval: got %h want deadbeef", write_value); end
        if (pending_count !== 6'd1) begin n_err++; $display("FAIL a_only_count_before: got %0d want 1", pending_count); end
        tick();
        a_valid = 1'b0;
        #1;
        n_vec += 3;
        if (busy_1 !== 1'b0) begin n_err++; $display("FAIL a_only_busy_after: got %b want 0", busy_1); end
        if (pending_count !== 6'd0) begin n_err++; $display("FAIL a_only_count_after: got %0d want 0", pending_count); end
        if (error !== 1'b0) begin n_err++; $display("FAIL a_only_error: got %b want 0", error); end
    endtask

    task automatic test_contention();
        bit exp_b;
        logic [XLEN-1:0] da, db;
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_b = (i % 2 == 0);
            da = $urandom;
            db = $urandom;
            a_valid = 1'b1; a_rd = 5'd3; a_data = da;
            b_valid = 1'b1; b_rd = 5'd4; b_data = db;
            issue_valid = 1'b1; issue_rd = exp_b ? 5'd4 : 5'd3;
            #1;
            n_vec += 3;
            if (b_ready !== exp_b || a_ready !== !exp_b) begin n_err++; $display("FAIL contend_grant[%0d]: got a=%b b=%b want b=%b", i, a_ready, b_ready, exp_b); end
            if (write_address !== (exp_b ? 5'd4 : 5'd3)) begin n_err++; $display("FAIL contend_waddr[%0d]: got %0d", i, write_address); end
            if (write_value !== (exp_b ? db : da)) begin n_err++; $display("FAIL contend_wval[%0d]: got %h want %h", i, write_value, exp_b ? db : da); end
            tick();
            n_vec++;
            if (last_b !== exp_b) begin n_err++; $display("FAIL contend_last_b[%0d]: got %b want %b", i, last_b, exp_b); end
        end
        idle_inputs();
        #1;
        n_vec += 2;
        if (error !== 1'b0) begin n_err++; $display("FAIL contend_error: got %b want 0", error); end
        if (pending_count !== 6'd2) begin n_err++; $display("FAIL contend_count: got %0d want 2", pending_count); end
    endtask

    task automatic test_busy_count();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle_inputs();
        check_addr_1 = 5'd7;
        #1;
        n_vec += 2;
        if (busy_1 !== 1'b1) begin n_err++; $display("FAIL busy7_set: got %b want 1", busy_1); end
        if (pending_count !== 6'd1) begin n_err++; $display("FAIL busy7_count: got %0d want 1", pending_count); end
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h0000_0777;
        #1;
        n_vec += 2;
        if (b_ready !== 1'b1) begin n_err++; $display("FAIL busy7_b_ready: got %b want 1", b_ready); end
        if (busy_1 !== 1'b1) begin n_err++; $display("FAIL busy7_same_cycle: got %b want 1", busy_1); end
        tick();
        b_valid = 1'b0;
        #1;
        n_vec += 2;
        if (busy_1 !== 1'b0) begin n_err++; $display("FAIL busy7_clear: got %b want 0", busy_1); end
        if (pending_count !== 6'd0) begin n_err++; $display("FAIL busy7_count_after: got %0d want 0", pending_count); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999_0000;
        tick();
        idle_inputs();
        check_addr_2 = 5'd9;
        #1;
        n_vec += 3;
        if (busy_2 !== 1'b1) begin n_err++; $display("FAIL same9_busy: got %b want 1", busy_2); end
        if (pending_count !== 6'd1) begin n_err++; $display("FAIL same9_count: got %0d want 1", pending_count); end
        if (error !== 1'b0) begin n_err++; $display("FAIL same9_error: got %b want 0", error); end
    endtask

    task automatic test_error_x0();
        do_reset();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1234_5678;
        #1;
        n_vec += 2;
        if (a_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", a_ready); end
        if (write_address !== 5'd0) begin n_err++; $display("FAIL x0_waddr: got %0d want 0", write_address); end
        tick();
        idle_inputs();
        #1;
        n_vec += 2;
        if (error !== 1'b0) begin n_err++; $display("FAIL x0_error: got %b want 0", error); end
        if (pending_count !== 6'd0) begin n_err++; $display("FAIL x0_count: got %0d want 0", pending_count); end
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'hC;
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (error !== 1'b1) begin n_err++; $display("FAIL x12_error_set: got %b want 1", error); end
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (error !== 1'b1) begin n_err++; $display("FAIL x12_error_sticky: got %b want 1", error); end
    endtask

    task automatic test_fill_reset();
        do_reset();
        for (int r = 1; r < 32; r++) begin
            issue_valid = 1'b1; issue_rd = AW'(r);
            tick();
        end
        idle_inputs();
        check_addr_1 = 5'd31; check_addr_2 = 5'd0;
        #1;
        n_vec += 3;
        if (pending_count !== 6'd31) begin n_err++; $display("FAIL fill_count: got %0d want 31", pending_count); end
        if (busy_1 !== 1'b1) begin n_err++; $display("FAIL fill_busy31: got %b want 1", busy_1); end
        if (busy_2 !== 1'b0) begin n_err++; $display("FAIL fill_busy0: got %b want 0", busy_2); end
        issue_valid = 1'b1; issue_rd = 5'd1;
        tick();
        n_vec++;
        if (error !== 1'b1) begin n_err++; $display("FAIL fill_reissue_error: got %b want 1", error); end
        issue_rd = 5'd2;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h5;
        check_addr_1 = 5'd5; check_addr_2 = 5'd31;
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_vec += 4;
        if (pending_count !== 6'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", pending_count); end
        if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b %b want 0 0", busy_1, busy_2); end
        if (error !== 1'b0) begin n_err++; $display("FAIL async_error: got %b want 0", error); end
        if (last_b !== 1'b0) begin n_err++; $display("FAIL async_last_b: got %b want 0", last_b); end
        idle_inputs();
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_random(input int cycles, input int a_hi, input int b_lo);
        bit ga, gb;
        logic [AW-1:0]   exp_wa;
        logic [XLEN-1:0] exp_wv;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            issue_valid  = ($urandom_range(0, 99) < 45);
            issue_rd     = AW'($urandom_range(0, 15));
            a_valid      = ($urandom_range(0, 99) < 50);
            a_rd         = AW'($urandom_range(0, a_hi));
            a_data       = $urandom;
            b_valid      = ($urandom_range(0, 99) < 50);
            b_rd         = AW'($urandom_range(b_lo, 15));
            b_data       = $urandom;
            check_addr_1 = AW'($urandom_range(0, 15));
            check_addr_2 = AW'($urandom_range(0, 31));
            #1;
            m_grant(ga, gb);
            exp_wa = gb ? b_rd : (ga ? a_rd : '0);
            exp_wv = gb ? b_data : (ga ? a_data : '0);
            n_vec += 8;
            if (a_ready !== ga || b_ready !== gb) begin n_err++; $display("FAIL rnd_grant[%0d]: got a=%b b=%b want a=%b b=%b", c, a_ready, b_ready, ga, gb); end
            if (write_address !== exp_wa) begin n_err++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", c, write_address, exp_wa); end
            if (write_value !== exp_wv) begin n_err++; $display("FAIL rnd_wval[%0d]: got %h want %h", c, write_value, exp_wv); end
            if (busy_1 !== m_pend[check_addr_1]) begin n_err++; $display("FAIL rnd_busy1[%0d]: got %b want %b", c, busy_1, m_pend[check_addr_1]); end
            if (busy_2 !== m_pend[check_addr_2]) begin n_err++; $display("FAIL rnd_busy2[%0d]: got %b want %b", c, busy_2, m_pend[check_addr_2]); end
            if (int'(pending_count) != m_count()) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, pending_count, m_count()); end
            if (error !== m_err) begin n_err++; $display("FAIL rnd_error[%0d]: got %b want %b", c, error, m_err); end
            if (last_b !== m_last_b) begin n_err++; $display("FAIL rnd_last_b[%0d]: got %b want %b", c, last_b, m_last_b); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_a_only();
        test_contention();
        test_busy_count();
        test_same_cycle();
        test_error_x0();
        test_fill_reset();
        test_random(300, 7, 8);
        test_random(300, 15, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
